mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_access_sequencer_if.sv | 27 ++
 rtl/mem_access_sequencer_rr_arbiter2.sv | 38 +++
 rtl/mem_access_sequencer.sv | 145 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access sequencer.
// Holds the FSM state encoding and the grant-owner constants.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage : mem_pkg

// File: rtl/mem_access_sequencer_if.sv
// Memory-side bus of the sequencer: latched address/data, strobes and completion.
// master = sequencer, slave = memory.
interface mem_access_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              MARin;
    logic              MDRin;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata, MARin, MDRin,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata, MARin, MDRin,
        output mem_rdata, mem_ready
    );

endinterface : mem_access_sequencer_if

// File: rtl/mem_access_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: req[0] = fetch, req[1] = data.
// A tie goes to the port opposite the last grant; last grant updates only when advance is high.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_grant_r;

    // Combinational grant selection from the pending requests and the last owner
    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt_idx = GRANT_FETCH;
            2'b10:   gnt_idx = GRANT_DATA;
            2'b11:   gnt_idx = ~last_grant_r;
            default: gnt_idx = GRANT_FETCH;
        endcase
    end

    // Last-grant register; resets to data so the first tie is won by fetch
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            last_grant_r <= GRANT_DATA;
        end else if (advance && gnt_valid) begin
            last_grant_r <= gnt_idx;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule : rr_arbiter2

// File: rtl/mem_access_sequencer.sv
// Sequences fetch and data port requests onto a single memory through IDLE/ADDR/ACCESS/DONE,
// with round-robin arbitration, a bounded wait for mem_ready and fully registered outputs.
module mem_access_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    if_req,
    input  logic [ADDR_W-1:0]       if_addr,
    output logic                    if_done,
    input  logic                    dt_req,
    input  logic                    dt_we,
    input  logic [ADDR_W-1:0]       dt_addr,
    input  logic [DATA_W-1:0]       dt_wdata,
    output logic                    dt_done,
    output logic [DATA_W-1:0]       rdata,
    output logic                    err,
    output logic                    busy,
    output logic                    grant,
    mem_access_sequencer_if.master  mem
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_r;
    logic             we_r;
    logic [CNT_W-1:0] cnt_r;
    logic             arb_valid_s;
    logic             arb_idx_s;
    logic             arb_adv_s;

    assign arb_adv_s = (state_r == ST_IDLE);

    rr_arbiter2 u_arb (
        .clock     (clock),
        .clear_n   (clear_n),
        .req       ({dt_req, if_req}),
        .advance   (arb_adv_s),
        .gnt_valid (arb_valid_s),
        .gnt_idx   (arb_idx_s)
    );

    // Sequencer FSM; every output is a register updated alongside the state
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r       <= ST_IDLE;
            we_r          <= 1'b0;
            cnt_r         <= CNT_ZERO;
            if_done       <= 1'b0;
            dt_done       <= 1'b0;
            rdata         <= {DATA_W{1'b0}};
            err           <= 1'b0;
            busy          <= 1'b0;
            grant         <= GRANT_FETCH;
            mem.mem_addr  <= {ADDR_W{1'b0}};
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            mem.mem_wdata <= {DATA_W{1'b0}};
            mem.MARin     <= 1'b0;
            mem.MDRin     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        state_r   <= ST_ADDR;
                        busy      <= 1'b1;
                        grant     <= arb_idx_s;
                        mem.MARin <= 1'b1;
                        if (arb_idx_s == GRANT_DATA) begin
                            mem.mem_addr  <= dt_addr;
                            mem.mem_wdata <= dt_wdata;
                            we_r          <= dt_we;
                        end else begin
                            // Fetch is read-only; the write data register keeps its old value
                            mem.mem_addr  <= if_addr;
                            we_r          <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    state_r       <= ST_ACCESS;
                    mem.MARin     <= 1'b0;
                    mem.mem_read  <= ~we_r;
                    mem.mem_write <= we_r;
                    cnt_r         <= CNT_ZERO;
                end
                ST_ACCESS: begin
                    if (mem.mem_ready) begin
                        state_r       <= ST_DONE;
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        err           <= 1'b0;
                        if_done       <= (grant == GRANT_FETCH);
                        dt_done       <= (grant == GRANT_DATA);
                        if (!we_r) begin
                            rdata     <= mem.mem_rdata;
                            mem.MDRin <= 1'b1;
                        end else begin
                            mem.MDRin <= 1'b0;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        // Timed out: finish with err and leave rdata untouched
                        state_r       <= ST_DONE;
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        err           <= 1'b1;
                        if_done       <= (grant == GRANT_FETCH);
                        dt_done       <= (grant == GRANT_DATA);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    if_done   <= 1'b0;
                    dt_done   <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    mem.MDRin <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    if_done       <= 1'b0;
                    dt_done       <= 1'b0;
                    err           <= 1'b0;
                    busy          <= 1'b0;
                    mem.mem_read  <= 1'b0;
                    mem.mem_write <= 1'b0;
                    mem.MARin     <= 1'b0;
                    mem.MDRin     <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_access_sequencer

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: directed transactions push expected
// completions into a queue, and a negedge monitor compares each done pulse against it.
module tb_mem_access_sequencer;
    import mem_pkg::*;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              clear_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_done;
    logic              dt_req = 1'b0;
    logic              dt_we = 1'b0;
    logic [ADDR_W-1:0] dt_addr = '0;
    logic [DATA_W-1:0] dt_wdata = '0;
    logic              dt_done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              grant;

    mem_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_access_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .dt_req   (dt_req),
        .dt_we    (dt_we),
        .dt_addr  (dt_addr),
        .dt_wdata (dt_wdata),
        .dt_done  (dt_done),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy),
        .grant    (grant),
        .mem      (mem_bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        bit          mdrin;
        bit          lat_en;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          resp_lat = 0;
    bit          stray = 1'b0;
    logic [31:0] rd_val = 32'h0;
    logic [31:0] model_rdata = 32'h0;
    int          acc_cnt = 0;
    bit          rd_seen, wr_seen, addr_ok, wdata_ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: ready after resp_lat ACCESS cycles (never when negative)
    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            mem_bus.mem_rdata = rd_val;
            if (mem_bus.mem_read || mem_bus.mem_write) begin
                mem_bus.mem_ready = (resp_lat >= 0) && (acc_cnt == resp_lat);
                acc_cnt++;
            end else begin
                mem_bus.mem_ready = stray;
                acc_cnt = 0;
            end
        end
    end

    // Monitor: every done pulse is matched against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mem_bus.mem_read && mem_bus.mem_write) check("strobe_exclusive", 64'd1, 64'd0);
            if (if_done || dt_done) begin
                if (if_done && dt_done) check("both_done", 64'd1, 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_port", 64'(dt_done), 64'(e.port));
                    check("grant", 64'(grant), 64'(e.port));
                    check("err", 64'(err), 64'(e.err));
                    check("rdata", 64'(rdata), 64'(e.rdata));
                    check("MDRin", 64'(mem_bus.MDRin), 64'(e.mdrin));
                    if (e.lat_en) check("latency", 64'(cyc), 64'(e.done_cyc));
                end
            end
        end
    end

    task automatic issue(input bit port, input bit we, input logic [8:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] val,
                         input bit push, input bit lat_en);
        exp_t e;
        resp_lat = lat;
        rd_val   = val;
        if (port) begin
            dt_req = 1'b1; dt_we = we; dt_addr = addr; dt_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (!we && lat >= 0) model_rdata = val;
        e.port     = port;
        e.err      = (lat < 0);
        e.rdata    = model_rdata;
        e.mdrin    = (!we && lat >= 0);
        e.lat_en   = lat_en;
        e.done_cyc = cyc + 3 + ((lat < 0) ? (TIMEOUT - 1) : lat);
        if (push) sb_q.push_back(e);
    endtask

    task automatic wait_done(input bit port, input logic [8:0] addr, input logic [31:0] wdata,
                             output bit rd_s, output bit wr_s, output bit a_ok, output bit w_ok);
        bit got = 1'b0;
        rd_s = 1'b0; wr_s = 1'b0; a_ok = 1'b1; w_ok = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (mem_bus.mem_read)  rd_s = 1'b1;
            if (mem_bus.mem_write) wr_s = 1'b1;
            if (busy && mem_bus.mem_addr !== addr)   a_ok = 1'b0;
            if (busy && mem_bus.mem_wdata !== wdata) w_ok = 1'b0;
            if (port ? dt_done : if_done) got = 1'b1;
        end
        if (port) dt_req = 1'b0; else if_req = 1'b0;
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic tie_round(input logic [31:0] val);
        @(negedge clock);
        issue(1'b0, 1'b0, 9'h021, 32'h0, 0, val, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 9'h122, 32'h0, 0, val, 1'b1, 1'b0);
        wait_done(1'b0, 9'h021, 32'h0, rd_seen, wr_seen, addr_ok, wdata_ok);
        wait_done(1'b1, 9'h122, 32'h0, rd_seen, wr_seen, addr_ok, wdata_ok);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'({if_done, dt_done, err}), 64'd0);
        check("rst_strobes", 64'({mem_bus.mem_read, mem_bus.mem_write, mem_bus.MARin, mem_bus.MDRin}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_bus.mem_wdata), 64'd0);
        clear_n = 1'b1;
        @(negedge clock);

        // Ties straight after reset: fetch, data, fetch, data
        tie_round(32'h0000_1111);
        tie_round(32'h2222_0000);

        // Fetch read, ready on first ACCESS cycle
        @(negedge clock);
        issue(1'b0, 1'b0, 9'h010, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        @(negedge clock);
        check("addr_MARin", 64'(mem_bus.MARin), 64'd1);
        check("addr_mem_addr", 64'(mem_bus.mem_addr), 64'h010);
        check("addr_busy", 64'(busy), 64'd1);
        check("addr_no_read", 64'(mem_bus.mem_read), 64'd0);
        @(negedge clock);
        check("access_MARin", 64'(mem_bus.MARin), 64'd0);
        check("access_read", 64'(mem_bus.mem_read), 64'd1);
        wait_done(1'b0, 9'h010, 32'h0, rd_seen, wr_seen, addr_ok, wdata_ok);
        check("fetch_no_write", 64'(wr_seen), 64'd0);

        // Data write to the top address
        @(negedge clock);
        issue(1'b1, 1'b1, 9'h1FF, 32'h1234_5678, 2, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done(1'b1, 9'h1FF, 32'h1234_5678, rd_seen, wr_seen, addr_ok, wdata_ok);
        check("write_no_read", 64'(rd_seen), 64'd0);
        check("write_strobe", 64'(wr_seen), 64'd1);
        check("write_addr_stable", 64'(addr_ok), 64'd1);
        check("write_wdata_stable", 64'(wdata_ok), 64'd1);

        // Data read with one wait cycle
        @(negedge clock);
        issue(1'b1, 1'b0, 9'h0A5, 32'h0, 1, 32'hA5A5_0F0F, 1'b1, 1'b1);
        wait_done(1'b1, 9'h0A5, 32'h1234_5678, rd_seen, wr_seen, addr_ok, wdata_ok);
        check("dread_strobe", 64'({rd_seen, wr_seen}), 64'b10);
        check("dread_addr_stable", 64'(addr_ok), 64'd1);

        // Timeout: memory never answers
        @(negedge clock);
        issue(1'b0, 1'b0, 9'h155, 32'h0, -1, 32'h0BAD_0BAD, 1'b1, 1'b1);
        wait_done(1'b0, 9'h155, 32'h0, rd_seen, wr_seen, addr_ok, wdata_ok);

        // mem_ready high outside ACCESS must not end the access early
        @(negedge clock);
        stray = 1'b1;
        @(negedge clock);
        issue(1'b0, 1'b0, 9'h033, 32'h0, 3, 32'h1357_9BDF, 1'b1, 1'b1);
        wait_done(1'b0, 9'h033, 32'h0, rd_seen, wr_seen, addr_ok, wdata_ok);
        stray = 1'b0;

        // Reset in the middle of ACCESS: no done, strobes drop at once
        @(negedge clock);
        issue(1'b0, 1'b0, 9'h044, 32'h0, -1, 32'h0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("pre_rst_read", 64'(mem_bus.mem_read), 64'd1);
        #2;
        clear_n = 1'b0;
        if_req  = 1'b0;
        #1;
        check("async_strobes", 64'({mem_bus.mem_read, mem_bus.mem_write, mem_bus.MARin}), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        model_rdata = 32'h0;
        repeat (3) @(negedge clock);
        tie_round(32'h3333_4444);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_access_sequencer
